// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
//   Shared definitions for the AXI4-Lite command master and its helpers:
//   - AXI response encodings
//   - master FSM state encoding
//   - fabric register / SRAM address map used by bring-up and self-test
//   - small response helper
// -----------------------------------------------------------------------------
package axi_lite_pkg;

   // AXI xRESP encodings
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Master FSM states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_DATA = 3'd4,
      ST_RSP     = 3'd5
   } state_t;

   // Timeout counter width; TIMEOUT_CYCLES must fit in it
   localparam int unsigned TMO_W = 16;

   // Fabric address map
   localparam logic [31:0] ADDR_CTRL        = 32'h0000_0000;
   localparam logic [31:0] ADDR_STATUS      = 32'h0000_0004;
   localparam logic [31:0] ADDR_BASE        = 32'h0000_0008;
   localparam logic [31:0] ADDR_DEPTH       = 32'h0000_000C;
   localparam logic [31:0] ADDR_STRIDE      = 32'h0000_0010;
   localparam logic [31:0] ADDR_HINTS       = 32'h0000_0014;
   localparam logic [31:0] ADDR_LANE_CNT    = 32'h0000_0018;
   localparam logic [31:0] ADDR_LANE_MASK   = 32'h0000_001C;
   localparam logic [31:0] ADDR_CYCLES      = 32'h0000_0020;
   localparam logic [31:0] ADDR_UTIL        = 32'h0000_0024;
   localparam logic [31:0] ADDR_SKIP_BASE   = 32'h0000_0028;
   localparam logic [31:0] ADDR_RESULTS     = 32'h0000_0100;
   localparam logic [31:0] ADDR_WEIGHT_SRAM = 32'h0000_1000;
   localparam logic [31:0] ADDR_INPUT_SRAM  = 32'h0000_2000;

   // SLVERR and DECERR both have bit 1 set
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// -----------------------------------------------------------------------------
// axi_lite_timeout_ctr
//   Saturating stall counter with a sticky timeout flag.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset
//     clr       - restart counting (state entry or any handshake); wins over inc
//     inc       - count this cycle (master is waiting on the slave)
//     flag      - sticky, set on the edge the count reaches LIMIT
// -----------------------------------------------------------------------------
module axi_lite_timeout_ctr
   import axi_lite_pkg::*;
#(
   parameter int unsigned LIMIT = 1024
)(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic flag
);

   localparam logic [TMO_W:0]   LIMIT_X = (TMO_W+1)'(LIMIT);
   localparam logic [TMO_W-1:0] CNT_MAX = '1;

   logic [TMO_W-1:0] count;
   logic [TMO_W:0]   count_inc;

   // One bit wider so the compare never wraps at saturation
   assign count_inc = {1'b0, count} + {{TMO_W{1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         flag  <= 1'b0;
      end else begin
         if (clr)
            count <= '0;
         else if (inc && (count != CNT_MAX))
            count <= count_inc[TMO_W-1:0];

         if (!clr && inc && (count_inc >= LIMIT_X))
            flag <= 1'b1;
      end
   end

endmodule

// File: rtl/axi_lite_master_v1.sv
// -----------------------------------------------------------------------------
// axi_lite_master_v1
//   Command-driven AXI4-Lite initiator, one outstanding single-beat transaction.
//   Ports:
//     m_axi_aclk, m_axi_areset   - clock, synchronous active-high reset
//     cmd_*                      - valid/ready command in (write flag, addr, wdata)
//     rsp_*                      - valid/ready response out (write echo, resp, rdata)
//     busy                       - FSM not in IDLE
//     timeout_err                - sticky: a wait state stalled TIMEOUT_CYCLES cycles
//     m_axi_aw/w/b/ar/r*         - AXI4-Lite master channels, all outputs registered
// -----------------------------------------------------------------------------
module axi_lite_master_v1
   import axi_lite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
)(
   input  logic                  m_axi_aclk,
   input  logic                  m_axi_areset,
   // command port
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   // response port
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [1:0]            rsp_resp,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   // status
   output logic                  busy,
   output logic                  timeout_err,
   // AXI write address
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   // AXI write data
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   // AXI write response
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   // AXI read address
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   // AXI read data
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   state_t state;

   logic cmd_hs, rsp_hs;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic aw_done, w_done;
   logic tmo_clr, tmo_inc;

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

   assign cmd_hs = cmd_valid && cmd_ready;
   assign rsp_hs = rsp_valid && rsp_ready;
   assign aw_hs  = m_axi_awvalid && m_axi_awready;
   assign w_hs   = m_axi_wvalid  && m_axi_wready;
   assign b_hs   = m_axi_bvalid  && m_axi_bready;
   assign ar_hs  = m_axi_arvalid && m_axi_arready;
   assign r_hs   = m_axi_rvalid  && m_axi_rready;

   // In WR_REQ a dropped valid means that channel already handshook,
   // so no separate done flags are needed.
   assign aw_done = !m_axi_awvalid || aw_hs;
   assign w_done  = !m_axi_wvalid  || w_hs;

   // Every state transition coincides with a cmd/rsp/AXI handshake, so
   // clearing on handshakes also covers clearing on state entry.
   assign tmo_clr = cmd_hs || rsp_hs || aw_hs || w_hs || b_hs || ar_hs || r_hs;
   assign tmo_inc = (state == ST_WR_REQ) || (state == ST_WR_RESP) ||
                    (state == ST_RD_REQ) || (state == ST_RD_DATA);

   axi_lite_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_tmo (
      .clk  (m_axi_aclk),
      .rst  (m_axi_areset),
      .clr  (tmo_clr),
      .inc  (tmo_inc),
      .flag (timeout_err)
   );

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         state         <= ST_IDLE;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_write     <= 1'b0;
         rsp_resp      <= RESP_OKAY;
         rsp_rdata     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_hs) begin
                  rsp_write <= cmd_write;
                  if (cmd_write) begin
                     // AW and W rise together: the fabric slave only
                     // commits a write when both valids coincide.
                     m_axi_awaddr  <= cmd_addr;
                     m_axi_wdata   <= cmd_wdata;
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     state         <= ST_WR_REQ;
                  end else begin
                     m_axi_araddr  <= cmd_addr;
                     m_axi_arvalid <= 1'b1;
                     state         <= ST_RD_REQ;
                  end
               end
            end

            ST_WR_REQ: begin
               if (aw_hs) m_axi_awvalid <= 1'b0;
               if (w_hs)  m_axi_wvalid  <= 1'b0;
               if (aw_done && w_done) begin
                  m_axi_bready <= 1'b1;
                  state        <= ST_WR_RESP;
               end
            end

            ST_WR_RESP: begin
               if (b_hs) begin
                  rsp_resp     <= m_axi_bresp;
                  rsp_rdata    <= '0;
                  m_axi_bready <= 1'b0;
                  rsp_valid    <= 1'b1;
                  state        <= ST_RSP;
               end
            end

            ST_RD_REQ: begin
               if (ar_hs) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  state         <= ST_RD_DATA;
               end
            end

            ST_RD_DATA: begin
               if (r_hs) begin
                  rsp_resp     <= m_axi_rresp;
                  rsp_rdata    <= m_axi_rdata;
                  m_axi_rready <= 1'b0;
                  rsp_valid    <= 1'b1;
                  state        <= ST_RSP;
               end
            end

            ST_RSP: begin
               if (rsp_hs) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_master_v1.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master_v1
//   Self-checking bench: reactive AXI-Lite slave with registered B/R, scoreboard
//   queue for responses, a vector table, and hand-timed corner sequences.
// -----------------------------------------------------------------------------
module tb_axi_lite_master_v1;
   import axi_lite_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid, rsp_ready = 1'b1, rsp_write;
   logic [1:0]    rsp_resp;
   logic [DW-1:0] rsp_rdata;
   logic          busy, timeout_err;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [DW-1:0] m_axi_wdata;
   logic          m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
   logic          m_axi_awready = 1'b1, m_axi_wready = 1'b1, m_axi_arready = 1'b1;
   logic [1:0]    m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
   logic          m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
   logic [DW-1:0] m_axi_rdata = '0;

   axi_lite_master_v1 #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .m_axi_aclk(clk), .m_axi_areset(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
      .busy(busy), .timeout_err(timeout_err),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic        w;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } exp_t;
   exp_t q[$];
   int rsp_cnt = 0;

   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         rsp_cnt++;
         if (q.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_cnt), 64'(0));
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_rsp_write", rsp_write, e.w);
            chk("sb_rsp_resp",  rsp_resp,  e.resp);
            chk("sb_rsp_rdata", rsp_rdata, e.rdata);
         end
      end
   end

   // ---------------- slave model ----------------
   // Handshakes are sampled mid-cycle; B/R are raised the cycle after the
   // request handshakes (registered slave).
   logic [1:0]  sl_resp  = RESP_OKAY;
   logic [31:0] sl_rdata = '0;
   logic [31:0] sl_awaddr = '0, sl_wdata = '0, sl_araddr = '0;
   logic aw_hs_s = 1'b0, w_hs_s = 1'b0, b_hs_s = 1'b0, ar_hs_s = 1'b0, r_hs_s = 1'b0;
   logic got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0;
   int   b_cnt = 0;

   always @(negedge clk) begin
      aw_hs_s = m_axi_awvalid && m_axi_awready;
      w_hs_s  = m_axi_wvalid  && m_axi_wready;
      b_hs_s  = m_axi_bvalid  && m_axi_bready;
      ar_hs_s = m_axi_arvalid && m_axi_arready;
      r_hs_s  = m_axi_rvalid  && m_axi_rready;
      if (aw_hs_s) sl_awaddr = m_axi_awaddr;
      if (w_hs_s)  sl_wdata  = m_axi_wdata;
      if (ar_hs_s) sl_araddr = m_axi_araddr;
      if (b_hs_s)  b_cnt++;
   end

   always @(posedge clk) begin
      #1;
      if (aw_hs_s) got_aw = 1'b1;
      if (w_hs_s)  got_w  = 1'b1;
      if (ar_hs_s) got_ar = 1'b1;
      if (b_hs_s)  m_axi_bvalid = 1'b0;
      if (r_hs_s)  m_axi_rvalid = 1'b0;
      if (got_aw && got_w && !m_axi_bvalid) begin
         m_axi_bvalid = 1'b1; m_axi_bresp = sl_resp; got_aw = 1'b0; got_w = 1'b0;
      end
      if (got_ar && !m_axi_rvalid) begin
         m_axi_rvalid = 1'b1; m_axi_rresp = sl_resp; m_axi_rdata = sl_rdata; got_ar = 1'b0;
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
      int n;
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin tick(); n++; end
      if (!cmd_ready) chk("cmd_accept_timeout", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 60) begin tick(); n++; end
      if (q.size() != 0) begin
         chk("drain_timeout", 64'(q.size()), 64'(0));
         q.delete();
      end
      tick();
   endtask

   typedef struct {
      logic        w;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  sresp;
      logic [31:0] srdata;
      logic [1:0]  eresp;
      logic [31:0] erdata;
   } vec_t;
   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int b0, r0;
      vecs[0] = '{1'b1, ADDR_CTRL,            32'h0000_0001, 2'b00, 32'h0,          2'b00, 32'h0};
      vecs[1] = '{1'b0, ADDR_RESULTS + 32'h4, 32'h0,         2'b00, 32'h0000_ABCD,  2'b00, 32'h0000_ABCD};
      vecs[2] = '{1'b1, ADDR_WEIGHT_SRAM,     32'h1122_3344, 2'b10, 32'h0,          2'b10, 32'h0};
      vecs[3] = '{1'b0, ADDR_INPUT_SRAM + 4,  32'h0,         2'b11, 32'hDEAD_BEEF,  2'b11, 32'hDEAD_BEEF};
      vecs[4] = '{1'b1, ADDR_LANE_MASK,       32'hFFFF_0000, 2'b01, 32'h0,          2'b01, 32'h0};
      vecs[5] = '{1'b0, ADDR_UTIL,            32'h0,         2'b10, 32'h8765_4321,  2'b10, 32'h8765_4321};

      // ---- reset state ----
      rst = 1'b1;
      tick(); tick();
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_awvalid", m_axi_awvalid, 1'b0);
      chk("rst_wvalid", m_axi_wvalid, 1'b0);
      chk("rst_arvalid", m_axi_arvalid, 1'b0);
      chk("rst_bready", m_axi_bready, 1'b0);
      chk("rst_rready", m_axi_rready, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_awaddr", m_axi_awaddr, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_timeout", timeout_err, 1'b0);
      rst = 1'b0;
      tick();

      // ---- write 0x08 <- 0x8000_0000, cycle-exact ----
      sl_resp = RESP_OKAY;
      q.push_back('{1'b1, RESP_OKAY, 32'h0});
      cmd_write = 1'b1; cmd_addr = ADDR_BASE; cmd_wdata = 32'h8000_0000; cmd_valid = 1'b1;
      chk("wr_c0_cmd_ready", cmd_ready, 1'b1);
      tick(); cmd_valid = 1'b0;
      chk("wr_c1_awvalid", m_axi_awvalid, 1'b1);
      chk("wr_c1_wvalid", m_axi_wvalid, 1'b1);
      chk("wr_c1_awaddr", m_axi_awaddr, ADDR_BASE);
      chk("wr_c1_wdata", m_axi_wdata, 32'h8000_0000);
      chk("wr_c1_bready", m_axi_bready, 1'b0);
      tick();
      chk("wr_c2_awvalid", m_axi_awvalid, 1'b0);
      chk("wr_c2_wvalid", m_axi_wvalid, 1'b0);
      chk("wr_c2_bready", m_axi_bready, 1'b1);
      tick();
      chk("wr_c3_rsp_valid", rsp_valid, 1'b1);
      chk("wr_c3_bready", m_axi_bready, 1'b0);
      tick();
      chk("wr_c4_rsp_valid", rsp_valid, 1'b0);
      chk("wr_c4_cmd_ready", cmd_ready, 1'b1);
      drain();

      // ---- read 0x104, cycle-exact ----
      sl_rdata = 32'h0000_ABCD;
      q.push_back('{1'b0, RESP_OKAY, 32'h0000_ABCD});
      cmd_write = 1'b0; cmd_addr = ADDR_RESULTS + 32'h4; cmd_valid = 1'b1;
      tick(); cmd_valid = 1'b0;
      chk("rd_c1_arvalid", m_axi_arvalid, 1'b1);
      chk("rd_c1_araddr", m_axi_araddr, 32'h104);
      tick();
      chk("rd_c2_arvalid", m_axi_arvalid, 1'b0);
      chk("rd_c2_rready", m_axi_rready, 1'b1);
      tick();
      chk("rd_c3_rsp_valid", rsp_valid, 1'b1);
      chk("rd_c3_rsp_rdata", rsp_rdata, 32'h0000_ABCD);
      drain();

      // ---- vector table ----
      for (int i = 0; i < 6; i++) begin
         sl_resp = vecs[i].sresp; sl_rdata = vecs[i].srdata;
         q.push_back('{vecs[i].w, vecs[i].eresp, vecs[i].erdata});
         send(vecs[i].w, vecs[i].addr, vecs[i].wdata);
         drain();
         if (vecs[i].w) begin
            chk("vec_awaddr", sl_awaddr, vecs[i].addr);
            chk("vec_wdata", sl_wdata, vecs[i].wdata);
         end else begin
            chk("vec_araddr", sl_araddr, vecs[i].addr);
         end
      end
      sl_resp = RESP_OKAY;

      // ---- write with W early, AW late ----
      b0 = b_cnt; r0 = rsp_cnt;
      m_axi_awready = 1'b0;
      q.push_back('{1'b1, RESP_OKAY, 32'h0});
      cmd_write = 1'b1; cmd_addr = ADDR_WEIGHT_SRAM; cmd_wdata = 32'hCAFE_0001; cmd_valid = 1'b1;
      tick(); cmd_valid = 1'b0;
      chk("split_c1_aw", m_axi_awvalid, 1'b1);
      chk("split_c1_w", m_axi_wvalid, 1'b1);
      tick();
      chk("split_c2_w", m_axi_wvalid, 1'b0);
      chk("split_c2_aw", m_axi_awvalid, 1'b1);
      chk("split_c2_awaddr", m_axi_awaddr, ADDR_WEIGHT_SRAM);
      chk("split_c2_wdata", m_axi_wdata, 32'hCAFE_0001);
      tick();
      chk("split_c3_aw", m_axi_awvalid, 1'b1);
      chk("split_c3_bready", m_axi_bready, 1'b0);
      tick();
      chk("split_c4_aw", m_axi_awvalid, 1'b1);
      m_axi_awready = 1'b1;
      tick();
      chk("split_c5_aw", m_axi_awvalid, 1'b0);
      chk("split_c5_bready", m_axi_bready, 1'b1);
      drain();
      chk("split_b_count", 64'(b_cnt - b0), 64'(1));
      chk("split_rsp_count", 64'(rsp_cnt - r0), 64'(1));

      // ---- response back-pressure with next command waiting ----
      rsp_ready = 1'b0;
      sl_rdata = 32'h1234_5678;
      q.push_back('{1'b0, RESP_OKAY, 32'h1234_5678});
      q.push_back('{1'b1, RESP_OKAY, 32'h0});
      cmd_write = 1'b0; cmd_addr = ADDR_STATUS; cmd_valid = 1'b1;
      tick();
      cmd_write = 1'b1; cmd_addr = ADDR_CTRL; cmd_wdata = 32'h0000_0001;
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", rsp_valid, 1'b1);
         chk("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
         chk("bp_rsp_write", rsp_write, 1'b0);
         chk("bp_cmd_ready", cmd_ready, 1'b0);
         tick();
      end
      rsp_ready = 1'b1;
      chk("bp_c8_cmd_ready", cmd_ready, 1'b0);
      tick();
      chk("bp_c9_cmd_ready", cmd_ready, 1'b1);
      chk("bp_c9_rsp_valid", rsp_valid, 1'b0);
      tick(); cmd_valid = 1'b0;
      chk("bp_c10_awvalid", m_axi_awvalid, 1'b1);
      chk("bp_c10_wvalid", m_axi_wvalid, 1'b1);
      drain();

      // ---- timeout on a stalled AR ----
      m_axi_arready = 1'b0;
      sl_rdata = 32'h0000_55AA;
      q.push_back('{1'b0, RESP_OKAY, 32'h0000_55AA});
      cmd_write = 1'b0; cmd_addr = ADDR_CYCLES; cmd_valid = 1'b1;
      tick(); cmd_valid = 1'b0;
      for (int i = 1; i < 8; i++) tick();
      chk("tmo_c8_err", timeout_err, 1'b0);
      tick();
      chk("tmo_c9_err", timeout_err, 1'b1);
      chk("tmo_c9_arvalid", m_axi_arvalid, 1'b1);
      tick();
      m_axi_arready = 1'b1;
      drain();
      chk("tmo_sticky", timeout_err, 1'b1);

      // ---- reset while waiting in WR_RESP ----
      r0 = rsp_cnt;
      cmd_write = 1'b1; cmd_addr = ADDR_DEPTH; cmd_wdata = 32'h0000_0040; cmd_valid = 1'b1;
      tick(); cmd_valid = 1'b0;
      tick();
      chk("rstwr_c2_bready", m_axi_bready, 1'b1);
      chk("rstwr_c2_bvalid", m_axi_bvalid, 1'b1);
      rst = 1'b1;
      tick();
      chk("rstwr_busy", busy, 1'b0);
      chk("rstwr_bready", m_axi_bready, 1'b0);
      chk("rstwr_cmd_ready", cmd_ready, 1'b1);
      chk("rstwr_timeout", timeout_err, 1'b0);
      chk("rstwr_rsp_valid", rsp_valid, 1'b0);
      rst = 1'b0;
      tick(); tick(); tick();
      chk("rstwr_no_rsp", 64'(rsp_cnt - r0), 64'(0));
      chk("rstwr_rsp_valid_late", rsp_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_lite_master_v1.md
Name: axi_lite_master_v1

Overview:
- Command-driven AXI4-Lite initiator: the host-side counterpart of the fabric register/SRAM slave.
- Accepts single-beat read/write commands on a valid/ready command port and issues them on the AXI-Lite master channels.
- Returns the response (bresp, or rresp plus rdata) on a valid/ready response port.
- Used by the bring-up sequencer and in-system self-test to:
  - load weight/input SRAM (0x1xxx/0x2xxx);
  - program control registers and start the fabric;
  - poll status and read results (0x100+) or profiling counters.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width
TIMEOUT_CYCLES, 1024, cycles without a handshake in any AXI wait state before timeout_err sets (1..65535)

Ports:
m_axi_aclk  in  1  clock
m_axi_areset  in  1  reset, synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_write  out  1  echo of cmd_write
rsp_resp  out  2  bresp or rresp
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky timeout flag
m_axi_awaddr  out  ADDR_WIDTH  write address
m_axi_awvalid  out  1
m_axi_awready  in  1
m_axi_wdata  out  DATA_WIDTH  write data
m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1
m_axi_araddr  out  ADDR_WIDTH
m_axi_arvalid  out  1
m_axi_arready  in  1
m_axi_rdata  in  DATA_WIDTH
m_axi_rresp  in  2
m_axi_rvalid  in  1
m_axi_rready  out  1

Behaviour:
- Reset: one clock, m_axi_aclk; reset m_axi_areset is synchronous and active-high. Reset values:
  - state=IDLE, busy=0;
  - all valid/ready outputs 0, except cmd_ready=1 (combinational, high in IDLE);
  - awaddr/wdata/araddr/rsp_rdata=0, rsp_resp=0, rsp_write=0, timeout_err=0, timeout counter=0.
- Reset mid-transaction: returns to IDLE next edge; any in-flight beat is dropped. Valids deassert in the reset cycle's next state.
- One outstanding transaction. Registered AXI outputs. cmd_ready = (state==IDLE).
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - On cmd handshake, capture addr/wdata/write.
  - Write: go to WR_REQ; awvalid=1 and wvalid=1 from the next cycle, in the same cycle (mandatory: our slave commits only when both valids coincide).
  - Read: go to RD_REQ; arvalid=1 from the next cycle.
- WR_REQ:
  - awvalid holds until awready is sampled high, then drops next cycle. wvalid behaves the same with wready, independently.
  - When both handshakes are done (same or different cycles), go to WR_RESP; bready=1.
  - A valid never drops before its ready. Address/data stay stable while valid.
- WR_RESP: on bvalid && bready, latch bresp, rsp_rdata=0, bready=0, go to RSP.
- RD_REQ: on arvalid && arready, arvalid=0, rready=1, go to RD_DATA.
- RD_DATA: on rvalid && rready, latch rdata/rresp, rready=0, go to RSP.
- RSP: rsp_valid=1, held with stable payload until rsp_ready; then IDLE. A new cmd can be accepted the cycle after.
- Latency against an always-ready slave with registered b/r: cmd handshake at cycle 0 → awvalid/wvalid (or arvalid) at cycle 1 → bvalid/rvalid at cycle 2 → rsp_valid at cycle 3. Back-to-back throughput is one transaction per 4 cycles.
- Timeout:
  - A 16-bit counter clears on each state entry and on any AXI handshake.
  - It increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA, and saturates.
  - When it reaches TIMEOUT_CYCLES, timeout_err sets (sticky until reset).
  - The transaction is not abandoned: valids stay asserted, preserving AXI legality.
- Error responses (SLVERR/DECERR) pass through rsp_resp unchanged; no retry.
- Unused RSP path: rsp_write echoes captured cmd_write.

Decomposition:
- Shared package `axi_lite_pkg` holds:
  - resp encodings RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - state enum localparams;
  - fabric address map constants: CTRL 0x00, STATUS 0x04, BASE 0x08, DEPTH 0x0C, STRIDE 0x10, HINTS 0x14, LANE_CNT 0x18, LANE_MASK 0x1C, CYCLES 0x20, UTIL 0x24, SKIP base 0x28, RESULTS base 0x100, WEIGHT SRAM 0x1000, INPUT SRAM 0x2000.
- One natural sub-module, `axi_lite_timeout_ctr`: saturating counter plus sticky flag.

Test Plan:
- Write 0x08 ← 0x8000_0000 against an always-ready slave → awvalid and wvalid high together for exactly cycle 1; bready high cycle 2; rsp_valid cycle 3 with rsp_resp=00, rsp_write=1, rsp_rdata=0.
- Read 0x104 with slave rdata=0x0000_ABCD at cycle 2 → arvalid 1 cycle; rsp_valid cycle 3 with rsp_rdata=0x0000_ABCD, rsp_resp=00.
- Write with wready at cycle 1 and awready at cycle 4 → wvalid drops at cycle 2, awvalid held cycles 1–4; awaddr/wdata stable; single B handshake; exactly one response.
- rsp_ready held low 5 cycles in RSP, with cmd_valid high throughout → rsp payload stable, cmd_ready=0; new command accepted the cycle after the rsp handshake.
- TIMEOUT_CYCLES=8, arready held 0 → timeout_err=1 after 8 stalled cycles; arvalid still 1; arready later asserted → transaction completes, timeout_err remains 1 until reset.
- Reset asserted in WR_RESP with bvalid pending → next cycle IDLE, bready=0, cmd_ready=1, timeout_err=0, no rsp_valid.
